// File: rtl/operand_fetch_if.sv
// operand_fetch_if: request, memory read port and ALU result bundle for operand_fetch
//   start/addr_mode/pc_in/x_reg/y_reg  fetch request from the decoder
//   mem_addr/mem_rd/mem_rdata          single synchronous memory read port
//   operand/eff_addr/pc_next           results held for the ALU
//   operand_valid/busy                 done pulse and sequencer activity
interface operand_fetch_if;
  logic start;
  logic [2:0] addr_mode;
  logic [15:0] pc_in;
  logic [7:0] x_reg, y_reg;
  logic [15:0] mem_addr;
  logic mem_rd;
  logic [7:0] mem_rdata;
  logic [7:0] operand;
  logic [15:0] eff_addr, pc_next;
  logic operand_valid, busy;
  modport master (
    output start, addr_mode, pc_in, x_reg, y_reg, mem_rdata,
    input mem_addr, mem_rd, operand, eff_addr, pc_next, operand_valid, busy
  );
  modport slave (
    input start, addr_mode, pc_in, x_reg, y_reg, mem_rdata,
    output mem_addr, mem_rd, operand, eff_addr, pc_next, operand_valid, busy
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: 6502 addressing-mode sequencer fetching the ALU B operand
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         operand_fetch_if.slave: request in, memory read port, results out
module operand_fetch (
  input logic clk,
  input logic rst_n,
  operand_fetch_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE, OP0_I, OP0_C, OP1_I, OP1_C, PTR0_I, PTR0_C, PTR1_I, PTR1_C, FIX, DATA_I, DATA_C, DONE
  } state_t;
  state_t state, state_n;
  logic [2:0] mode;
  logic [15:0] pc, ea;
  logic [7:0] x, y, lo, idx;
  logic [8:0] lo_sum;
  logic [15:0] ind_sum;
  // lo holds the operand low byte, or the pointer low byte once PTR0 completes
  assign idx = (mode == 3'd2 || mode == 3'd5) ? x : (mode == 3'd3 || mode == 3'd6 || mode == 3'd7) ? y : 8'h00;
  assign lo_sum = {1'b0, lo} + {1'b0, idx};
  assign ind_sum = {bus.mem_rdata, lo} + {8'h00, idx};
  assign bus.mem_rd = state inside {OP0_I, OP1_I, PTR0_I, PTR1_I, DATA_I};
  assign bus.busy = state != IDLE;
  assign bus.operand_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? OP0_I : IDLE;
      OP0_I: state_n = OP0_C;
      OP0_C: state_n = mode == 3'd0 ? DONE : mode == 3'd7 ? PTR0_I : mode[2] ? OP1_I : DATA_I;
      OP1_I: state_n = OP1_C;
      PTR0_I: state_n = PTR0_C;
      PTR0_C: state_n = PTR1_I;
      PTR1_I: state_n = PTR1_C;
      OP1_C, PTR1_C: state_n = lo_sum[8] ? FIX : DATA_I;
      FIX: state_n = DATA_I;
      DATA_I: state_n = DATA_C;
      DATA_C: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // mem_addr only moves when the next state issues a read, so it holds between reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode <= '0;
      pc <= '0;
      x <= '0;
      y <= '0;
      lo <= '0;
      ea <= '0;
      bus.mem_addr <= '0;
      bus.operand <= '0;
      bus.eff_addr <= '0;
      bus.pc_next <= '0;
    end else
      case (state)
        IDLE:
          if (bus.start) begin
            mode <= bus.addr_mode;
            pc <= bus.pc_in;
            x <= bus.x_reg;
            y <= bus.y_reg;
            bus.mem_addr <= bus.pc_in;
          end
        OP0_C: begin
          lo <= bus.mem_rdata;
          if (mode == 3'd0) begin
            bus.operand <= bus.mem_rdata;
            bus.eff_addr <= pc;
            bus.pc_next <= pc + 16'd1;
          end else if (mode == 3'd7) bus.mem_addr <= {8'h00, bus.mem_rdata};
          else if (mode[2]) bus.mem_addr <= pc + 16'd1;
          else begin
            ea <= {8'h00, bus.mem_rdata + idx};
            bus.mem_addr <= {8'h00, bus.mem_rdata + idx};
          end
        end
        PTR0_C: begin
          lo <= bus.mem_rdata;
          bus.mem_addr <= {8'h00, lo + 8'd1};
        end
        OP1_C, PTR1_C: begin
          ea <= ind_sum;
          if (!lo_sum[8]) bus.mem_addr <= ind_sum;
        end
        FIX: bus.mem_addr <= ea;
        DATA_C: begin
          bus.operand <= bus.mem_rdata;
          bus.eff_addr <= ea;
          bus.pc_next <= pc + ((mode inside {3'd4, 3'd5, 3'd6}) ? 16'd2 : 16'd1);
        end
        default: ;
      endcase
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and randomized checks of operand_fetch against a behavioural model
module tb_operand_fetch;
  logic clk = 0;
  logic rst_n = 0;
  operand_fetch_if bus ();
  operand_fetch dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  int checks = 0, errors = 0;
  int obs_vc, obs_nrd, obs_glitch;
  logic obs_busy1;
  logic [63:0] obs_rdv;
  logic obs_rdc [0:24];
  logic [7:0] obs_op;
  logic [15:0] obs_ea, obs_pn;

  logic [15:0] exp_ea, exp_pn;
  logic [7:0] exp_op;
  logic [63:0] exp_rdv;
  int exp_lat, exp_nrd;

  task automatic run_fetch(input logic [2:0] m, input logic [15:0] p, input logic [7:0] xv, input logic [7:0] yv);
    logic [15:0] last;
    obs_vc = 0; obs_nrd = 0; obs_glitch = 0; obs_rdv = '0; obs_busy1 = 0; last = '0;
    for (int i = 0; i <= 24; i++) obs_rdc[i] = 0;
    @(negedge clk);
    bus.start = 1; bus.addr_mode = m; bus.pc_in = p; bus.x_reg = xv; bus.y_reg = yv;
    @(posedge clk); #1;
    bus.start = 0;
    bus.addr_mode = 3'($urandom); bus.pc_in = 16'($urandom);
    bus.x_reg = 8'($urandom); bus.y_reg = 8'($urandom);
    for (int n = 1; n <= 20 && obs_vc == 0; n++) begin
      @(negedge clk);
      if (n == 1) obs_busy1 = bus.busy;
      obs_rdc[n] = bus.mem_rd;
      if (bus.mem_rd) begin
        obs_rdv = {obs_rdv[47:0], bus.mem_addr};
        obs_nrd++;
        last = bus.mem_addr;
      end else if (bus.mem_addr !== last) obs_glitch++;
      if (bus.operand_valid) begin
        obs_vc = n; obs_op = bus.operand; obs_ea = bus.eff_addr; obs_pn = bus.pc_next;
      end
    end
  endtask

  task automatic model(input logic [2:0] m, input logic [15:0] p, input logic [7:0] xv, input logic [7:0] yv);
    logic [7:0] b0, b1, idx, zl, zh;
    b0 = mem[p];
    b1 = mem[p + 16'd1];
    idx = (m == 3'd2 || m == 3'd5) ? xv : (m == 3'd3 || m == 3'd6 || m == 3'd7) ? yv : 8'h00;
    exp_rdv = {48'h0, p};
    exp_nrd = 1;
    exp_pn = (m >= 3'd4 && m <= 3'd6) ? p + 16'd2 : p + 16'd1;
    if (m == 3'd0) begin
      exp_ea = p; exp_lat = 3;
    end else if (m <= 3'd3) begin
      exp_ea = {8'h00, 8'(b0 + idx)}; exp_lat = 5;
    end else if (m <= 3'd6) begin
      exp_ea = {b1, b0} + {8'h00, idx};
      exp_lat = (exp_ea[15:8] != b1) ? 8 : 7;
      exp_rdv = {exp_rdv[47:0], p + 16'd1}; exp_nrd++;
    end else begin
      zl = mem[{8'h00, b0}];
      zh = mem[{8'h00, 8'(b0 + 8'd1)}];
      exp_ea = {zh, zl} + {8'h00, idx};
      exp_lat = (exp_ea[15:8] != zh) ? 10 : 9;
      exp_rdv = {exp_rdv[31:0], 8'h00, b0, 8'h00, 8'(b0 + 8'd1)}; exp_nrd += 2;
    end
    if (m != 3'd0) begin
      exp_rdv = {exp_rdv[47:0], exp_ea}; exp_nrd++;
    end
    exp_op = mem[exp_ea];
  endtask

  task automatic test_reset;
    bus.start = 0; bus.addr_mode = 0; bus.pc_in = 0; bus.x_reg = 0; bus.y_reg = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_addr, bus.mem_rd, bus.operand, bus.eff_addr, bus.pc_next, bus.operand_valid, bus.busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: addr=%h rd=%b op=%h ea=%h pn=%h v=%b busy=%b required all zero",
               bus.mem_addr, bus.mem_rd, bus.operand, bus.eff_addr, bus.pc_next, bus.operand_valid, bus.busy);
    end
    rst_n = 1;
  endtask

  task automatic test_imm;
    mem[16'h0200] = 8'h42;
    run_fetch(3'd0, 16'h0200, 8'h00, 8'h00);
    checks++;
    if (obs_vc !== 3) begin errors++; $display("FAIL imm_latency: got %0d required 3", obs_vc); end
    checks++;
    if (obs_nrd !== 1 || obs_rdv !== 64'h0200) begin errors++; $display("FAIL imm_reads: got %0d reads %h required 1 read 0200", obs_nrd, obs_rdv); end
    checks++;
    if ({obs_op, obs_ea, obs_pn} !== {8'h42, 16'h0200, 16'h0201}) begin
      errors++; $display("FAIL imm_result: op=%h ea=%h pn=%h required 42 0200 0201", obs_op, obs_ea, obs_pn);
    end
    checks++;
    if (obs_busy1 !== 1'b1) begin errors++; $display("FAIL imm_busy_cycle1: got %b required 1", obs_busy1); end
  endtask

  task automatic test_zpx_wrap;
    logic [7:0] v;
    v = 8'($urandom);
    mem[16'h0300] = 8'hF0; mem[16'h0010] = v;
    run_fetch(3'd2, 16'h0300, 8'h20, 8'h00);
    checks++;
    if (obs_vc !== 5) begin errors++; $display("FAIL zpx_latency: got %0d required 5", obs_vc); end
    checks++;
    if (obs_nrd !== 2 || obs_rdv !== 64'h0300_0010) begin errors++; $display("FAIL zpx_reads: got %0d reads %h required 0300 0010", obs_nrd, obs_rdv); end
    checks++;
    if ({obs_op, obs_ea, obs_pn} !== {v, 16'h0010, 16'h0301}) begin
      errors++; $display("FAIL zpx_result: op=%h ea=%h pn=%h required %h 0010 0301", obs_op, obs_ea, obs_pn, v);
    end
  endtask

  task automatic test_absx_cross;
    logic [7:0] v, w;
    v = 8'($urandom); w = 8'($urandom);
    mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'h12; mem[16'h1300] = v; mem[16'h12FF] = w;
    run_fetch(3'd5, 16'h0400, 8'h01, 8'h00);
    checks++;
    if (obs_vc !== 8) begin errors++; $display("FAIL absx_cross_latency: got %0d required 8", obs_vc); end
    checks++;
    if (obs_nrd !== 3 || obs_rdv !== 64'h0400_0401_1300) begin errors++; $display("FAIL absx_cross_reads: got %0d reads %h required 0400 0401 1300", obs_nrd, obs_rdv); end
    checks++;
    if (obs_rdc[5] !== 1'b0) begin errors++; $display("FAIL absx_fix_rd: mem_rd=%b in FIX required 0", obs_rdc[5]); end
    checks++;
    if ({obs_op, obs_ea, obs_pn} !== {v, 16'h1300, 16'h0402}) begin
      errors++; $display("FAIL absx_cross_result: op=%h ea=%h pn=%h required %h 1300 0402", obs_op, obs_ea, obs_pn, v);
    end
    run_fetch(3'd5, 16'h0400, 8'h00, 8'h00);
    checks++;
    if (obs_vc !== 7) begin errors++; $display("FAIL absx_nocross_latency: got %0d required 7", obs_vc); end
    checks++;
    if ({obs_op, obs_ea} !== {w, 16'h12FF}) begin
      errors++; $display("FAIL absx_nocross_result: op=%h ea=%h required %h 12FF", obs_op, obs_ea, w);
    end
  endtask

  task automatic test_izy_wrap;
    logic [7:0] v, w;
    v = 8'($urandom); w = 8'($urandom);
    mem[16'h0500] = 8'hFF; mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h40; mem[16'h4005] = v; mem[16'h4103] = w;
    run_fetch(3'd7, 16'h0500, 8'h00, 8'h05);
    checks++;
    if (obs_vc !== 9) begin errors++; $display("FAIL izy_latency: got %0d required 9", obs_vc); end
    checks++;
    if (obs_nrd !== 4 || obs_rdv !== 64'h0500_00FF_0000_4005) begin errors++; $display("FAIL izy_reads: got %0d reads %h required 0500 00FF 0000 4005", obs_nrd, obs_rdv); end
    checks++;
    if ({obs_op, obs_ea, obs_pn} !== {v, 16'h4005, 16'h0501}) begin
      errors++; $display("FAIL izy_result: op=%h ea=%h pn=%h required %h 4005 0501", obs_op, obs_ea, obs_pn, v);
    end
    mem[16'h00FF] = 8'hFE;
    run_fetch(3'd7, 16'h0500, 8'h00, 8'h05);
    checks++;
    if (obs_vc !== 10) begin errors++; $display("FAIL izy_cross_latency: got %0d required 10", obs_vc); end
    checks++;
    if ({obs_op, obs_ea} !== {w, 16'h4103}) begin
      errors++; $display("FAIL izy_cross_result: op=%h ea=%h required %h 4103", obs_op, obs_ea, w);
    end
  endtask

  task automatic test_back_to_back;
    mem[16'h0900] = 8'h5A; mem[16'h0A00] = 8'h44; mem[16'h0044] = 8'hC3;
    run_fetch(3'd0, 16'h0900, 8'h00, 8'h00);
    run_fetch(3'd1, 16'h0A00, 8'h00, 8'h00);
    checks++;
    if (obs_vc !== 5 || obs_op !== 8'hC3 || obs_ea !== 16'h0044) begin
      errors++; $display("FAIL back_to_back: vc=%0d op=%h ea=%h required 5 C3 0044", obs_vc, obs_op, obs_ea);
    end
  endtask

  task automatic test_start_held;
    logic [7:0] v;
    logic [15:0] mask;
    v = 8'($urandom);
    mem[16'h0800] = 8'h33; mem[16'h0033] = v;
    mask = '0;
    @(negedge clk);
    bus.start = 1; bus.addr_mode = 3'd1; bus.pc_in = 16'h0800;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (bus.operand_valid) mask[n] = 1'b1;
      if (n == 11) bus.start = 0;
    end
    checks++;
    if (mask !== 16'h0820) begin errors++; $display("FAIL start_held_pulses: mask=%h required 0820", mask); end
    checks++;
    if (bus.operand !== v || bus.eff_addr !== 16'h0033) begin
      errors++; $display("FAIL start_held_result: op=%h ea=%h required %h 0033", bus.operand, bus.eff_addr, v);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    for (int rc = 3; rc <= 4; rc++) begin
      mem[16'h0600] = 8'h34; mem[16'h0601] = 8'h12; mem[16'h0700] = 8'h9E;
      pulses = 0;
      @(negedge clk);
      bus.start = 1; bus.addr_mode = 3'd4; bus.pc_in = 16'h0600;
      @(posedge clk); #1;
      bus.start = 0;
      for (int n = 1; n <= rc; n++) @(negedge clk);
      #2 rst_n = 0;
      #1;
      checks++;
      if ({bus.mem_addr, bus.mem_rd, bus.operand, bus.eff_addr, bus.pc_next, bus.operand_valid, bus.busy} !== '0) begin
        errors++;
        $display("FAIL reset_mid_c%0d: addr=%h rd=%b op=%h ea=%h pn=%h v=%b busy=%b required all zero",
                 rc, bus.mem_addr, bus.mem_rd, bus.operand, bus.eff_addr, bus.pc_next, bus.operand_valid, bus.busy);
      end
      repeat (3) begin
        @(negedge clk);
        if (bus.operand_valid !== 1'b0) pulses++;
      end
      rst_n = 1;
      repeat (2) begin
        @(negedge clk);
        if (bus.operand_valid !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL reset_mid_no_valid: %0d pulses required 0", pulses); end
      run_fetch(3'd0, 16'h0700, 8'h00, 8'h00);
      checks++;
      if (obs_vc !== 3 || obs_op !== 8'h9E) begin
        errors++; $display("FAIL reset_mid_restart: vc=%0d op=%h required 3 9E", obs_vc, obs_op);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0] m;
    logic [15:0] p;
    logic [7:0] xv, yv;
    for (int it = 0; it < 60; it++) begin
      m = 3'($urandom);
      p = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      xv = 8'($urandom); yv = 8'($urandom);
      model(m, p, xv, yv);
      run_fetch(m, p, xv, yv);
      checks++;
      if (obs_vc !== exp_lat) begin errors++; $display("FAIL rand_latency mode=%0d pc=%h: got %0d required %0d", m, p, obs_vc, exp_lat); end
      checks++;
      if (obs_nrd !== exp_nrd || obs_rdv !== exp_rdv) begin
        errors++; $display("FAIL rand_reads mode=%0d pc=%h: got %0d reads %h required %0d reads %h", m, p, obs_nrd, obs_rdv, exp_nrd, exp_rdv);
      end
      checks++;
      if ({obs_op, obs_ea, obs_pn} !== {exp_op, exp_ea, exp_pn}) begin
        errors++; $display("FAIL rand_result mode=%0d pc=%h: op=%h ea=%h pn=%h required %h %h %h", m, p, obs_op, obs_ea, obs_pn, exp_op, exp_ea, exp_pn);
      end
      checks++;
      if (obs_glitch != 0 || obs_busy1 !== 1'b1) begin
        errors++; $display("FAIL rand_addr_hold mode=%0d: moved %0d times, busy1=%b required 0 moves busy1=1", m, obs_glitch, obs_busy1);
      end
      if (it % 3 == 0) begin
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.operand_valid, bus.operand, bus.eff_addr, bus.pc_next} !== {2'b00, exp_op, exp_ea, exp_pn}) begin
          errors++; $display("FAIL rand_held: busy=%b v=%b op=%h ea=%h pn=%h required 0 0 %h %h %h",
                             bus.busy, bus.operand_valid, bus.operand, bus.eff_addr, bus.pc_next, exp_op, exp_ea, exp_pn);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset;
    test_imm;
    test_zpx_wrap;
    test_absx_cross;
    test_izy_wrap;
    test_back_to_back;
    test_start_held;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
